mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Memory interface stage between the CPU datapath bus and the 512 x 32 RAM.
- Holds the memory address register (MAR) and memory data register (MDR).
- Accepts a single-cycle access request and sequences exactly one RAM read or write.
- Captures read data into MDR, then signals completion with a one-cycle done pulse.

Parameters:
ADDR_WIDTH, 9, RAM address width; MAR bits above this are out of range.
DATA_WIDTH, 32, bus, MDR and RAM data width.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
BusMuxOut  input  32  datapath bus value.
MARin  input  1  load MAR from BusMuxOut (honoured only in IDLE).
MDRin  input  1  load MDR from BusMuxOut (honoured only in IDLE).
mem_req  input  1  start an access; sampled only in IDLE.
mem_we  input  1  access type, sampled with mem_req: 1 = write, 0 = read.
MDR_q  output  32  current MDR contents, drives the bus-side mux.
busy  output  1  high in every state except IDLE.
mem_done  output  1  one-cycle completion pulse.
addr_err  output  1  one-cycle pulse coincident with mem_done when MAR[31:ADDR_WIDTH] != 0.
ram_Read  output  1  RAM read strobe.
ram_Write  output  1  RAM write strobe.
ram_Address  output  9  always MAR[ADDR_WIDTH-1:0].
ram_Mdatain  output  32  always MDR.
ram_data_output  input  32  RAM registered read data; valid one edge after a read strobe.

Behaviour:
- Reset: state = IDLE; MAR = 0; MDR = 0. All outputs 0: busy, mem_done, addr_err, ram_Read, ram_Write, MDR_q, ram_Address.
- Reset gating: ram_Read and ram_Write are ANDed with ~Reset, so no RAM access occurs in any reset cycle, including a reset mid-operation.
- FSM states: IDLE, WR, RD, RD_CAP, DONE.
  - IDLE, mem_req=1: latch type; mem_we=1 -> WR, mem_we=0 -> RD. MARin/MDRin in the same cycle load at the same edge, so the access uses the newly loaded values.
  - IDLE, mem_req=0: stay in IDLE.
  - WR: ram_Write = ~oob for exactly this cycle -> DONE.
  - RD: ram_Read = ~oob for exactly this cycle -> RD_CAP.
  - RD_CAP: MDR <= ram_data_output if ~oob; MDR unchanged if oob -> DONE.
  - DONE: mem_done = 1; addr_err = oob -> IDLE.
- oob = |MAR[31:ADDR_WIDTH], evaluated combinationally from the MAR value held during the access.
- Latency, counting from the edge that samples mem_req in IDLE:
  - Write: mem_done high in the 2nd cycle after that edge.
  - Read: mem_done high in the 3rd cycle after that edge; MDR_q already holds the read data when mem_done is high.
- While busy: MARin, MDRin and mem_req are ignored; MAR and MDR stay frozen except for the RD_CAP capture.
- mem_req held high continuously: a new access is accepted on the first IDLE cycle after DONE. Throughput is one write per 3 cycles or one read per 4 cycles.
- ram_Read and ram_Write are never high together. Each strobe is high for exactly one cycle per access and never outside WR/RD.
- Moore outputs (busy, mem_done, addr_err, strobes) decode from registered state only; the one exception is the Reset gate on the strobes.

Test Plan:
1. Reset: hold Reset 2 cycles -> all outputs 0, busy=0. Then pulse mem_req=0 -> no strobes.
2. Write: BusMuxOut=0x00000005 with MARin; BusMuxOut=0xDEADBEEF with MDRin; mem_req=1, mem_we=1 -> ram_Write high 1 cycle with ram_Address=5, ram_Mdatain=0xDEADBEEF; mem_done 2 cycles after the request edge; addr_err=0.
3. Read (behavioural RAM model attached): MDRin with bus=0, then read address 5 -> ram_Read high 1 cycle; MDR_q=0xDEADBEEF when mem_done rises, 3 cycles after the request edge.
4. Out of range: MAR=0x00000200, read with MDR=0x12345678 -> no ram_Read/ram_Write; mem_done and addr_err pulse together; MDR_q stays 0x12345678. Repeat as a write -> no ram_Write.
5. Busy lockout and back-to-back: MARin with bus=7 during a read's RD_CAP -> MAR unchanged. Hold mem_req=1, mem_we=0 -> reads complete every 4 cycles, busy low exactly one cycle between them.
6. Reset mid-operation: assert Reset in the WR cycle -> ram_Write=0 that cycle, RAM model location unchanged, next state IDLE, no mem_done.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory access stage between the CPU datapath bus and a 512 x 32 RAM.
// Holds MAR/MDR, runs one RAM read or write per request and reports
// completion with a single-cycle done pulse (plus an out-of-range flag).
module mem_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  mem_req,
  input  logic                  mem_we,
  output logic [DATA_WIDTH-1:0] MDR_q,
  output logic                  busy,
  output logic                  mem_done,
  output logic                  addr_err,
  output logic                  ram_Read,
  output logic                  ram_Write,
  output logic [ADDR_WIDTH-1:0] ram_Address,
  output logic [DATA_WIDTH-1:0] ram_Mdatain,
  input  logic [DATA_WIDTH-1:0] ram_data_output
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RD_CAP = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mdr;
  logic                  oob;
  logic                  rd_strobe;
  logic                  wr_strobe;

  // Any MAR bit above the RAM address field makes the access out of range.
  assign oob = |mar[DATA_WIDTH-1:ADDR_WIDTH];

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // MAR/MDR: bus loads only while idle; MDR also captures read data in RD_CAP.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (state == IDLE) begin
        if (MARin) mar <= BusMuxOut;
        if (MDRin) mdr <= BusMuxOut;
      end else if ((state == RD_CAP) && !oob) begin
        mdr <= ram_data_output;
      end
    end
  end

  // Next-state decode and Moore outputs from the registered state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    mem_done  = 1'b0;
    addr_err  = 1'b0;
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (mem_req) state_nxt = mem_we ? WR : RD;
      end
      WR: begin
        wr_strobe = ~oob;
        state_nxt = DONE;
      end
      RD: begin
        rd_strobe = ~oob;
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        state_nxt = DONE;
      end
      DONE: begin
        mem_done  = 1'b1;
        addr_err  = oob;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Strobes are gated by Reset directly so a reset cycle never touches the RAM,
  // even when it lands in the middle of an access.
  assign ram_Read    = rd_strobe & ~Reset;
  assign ram_Write   = wr_strobe & ~Reset;
  assign ram_Address = mar[ADDR_WIDTH-1:0];
  assign ram_Mdatain = mdr;
  assign MDR_q       = mdr;

endmodule
